// File: rtl/l2_read_arbiter.sv
// Round-robin arbiter sharing one L2 read port between I-cache and D-cache.
// Requests are staged into a single L2 address register; returned bursts are routed by an in-order source FIFO.
module l2_read_arbiter #(
  parameter int B  = 9,
  parameter int W  = 7,
  parameter int P  = 2,
  parameter int AW = 30
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                ADDR_VALID_INS,
  output logic                ADDR_READY_INS,
  input  logic [AW-1:0]       ADDR_INS,
  output logic                DATA_VALID_INS,
  input  logic                DATA_READY_INS,
  output logic [(1<<W)-1:0]   DATA_INS,
  input  logic                ADDR_VALID_DAT,
  output logic                ADDR_READY_DAT,
  input  logic [AW-1:0]       ADDR_DAT,
  output logic                DATA_VALID_DAT,
  input  logic                DATA_READY_DAT,
  output logic [(1<<W)-1:0]   DATA_DAT,
  output logic                ADDR_TO_L2_VALID,
  input  logic                ADDR_TO_L2_READY,
  output logic [AW-1:0]       ADDR_TO_L2,
  input  logic                DATA_FROM_L2_VALID,
  output logic                DATA_FROM_L2_READY,
  input  logic [(1<<W)-1:0]   DATA_FROM_L2,
  output logic [P:0]          OUTSTANDING,
  output logic                PROTO_ERR
);

  localparam int BW    = B - W;
  localparam int DEPTH = 1 << P;
  localparam logic [P:0]    FULL_CNT  = (P+1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'((1 << BW) - 1);

  logic              stage_valid_q, stage_valid_d;
  logic [AW-1:0]     stage_addr_q, stage_addr_d;
  logic              pref_dat_q, pref_dat_d;
  logic [DEPTH-1:0]  order_q, order_d;
  logic [P-1:0]      wr_ptr_q, wr_ptr_d;
  logic [P-1:0]      rd_ptr_q, rd_ptr_d;
  logic [P:0]        count_q, count_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              proto_err_q, proto_err_d;

  logic load_en, grant_ins, grant_dat, push;
  logic fifo_empty, head_dat, beat_acc, pop;

  // Arbitration: the preferred side only matters when both caches request together.
  always_comb begin
    load_en   = (!stage_valid_q || ADDR_TO_L2_READY) && (count_q != FULL_CNT);
    grant_ins = 1'b0;
    grant_dat = 1'b0;
    if (load_en) begin
      if (ADDR_VALID_INS && ADDR_VALID_DAT) begin
        grant_dat = pref_dat_q;
        grant_ins = !pref_dat_q;
      end else begin
        grant_ins = ADDR_VALID_INS;
        grant_dat = ADDR_VALID_DAT;
      end
    end else begin
      grant_ins = 1'b0;
      grant_dat = 1'b0;
    end
    push = grant_ins || grant_dat;
  end

  // Return routing follows the FIFO head; beats offered with nothing outstanding are refused.
  always_comb begin
    fifo_empty         = (count_q == '0);
    head_dat           = order_q[rd_ptr_q];
    DATA_VALID_INS     = 1'b0;
    DATA_VALID_DAT     = 1'b0;
    DATA_FROM_L2_READY = 1'b0;
    if (!fifo_empty) begin
      if (head_dat) begin
        DATA_VALID_DAT     = DATA_FROM_L2_VALID;
        DATA_FROM_L2_READY = DATA_READY_DAT;
      end else begin
        DATA_VALID_INS     = DATA_FROM_L2_VALID;
        DATA_FROM_L2_READY = DATA_READY_INS;
      end
    end else begin
      DATA_FROM_L2_READY = 1'b0;
    end
    beat_acc = DATA_FROM_L2_VALID && DATA_FROM_L2_READY;
    pop      = beat_acc && (beat_q == LAST_BEAT);
  end

  assign ADDR_READY_INS   = grant_ins;
  assign ADDR_READY_DAT   = grant_dat;
  assign DATA_INS         = DATA_FROM_L2;
  assign DATA_DAT         = DATA_FROM_L2;
  assign ADDR_TO_L2_VALID = stage_valid_q;
  assign ADDR_TO_L2       = stage_addr_q;
  assign OUTSTANDING      = count_q;
  assign PROTO_ERR        = proto_err_q;

  // Next-state for the address stage, order FIFO, beat counter and error flag.
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    pref_dat_d    = pref_dat_q;
    order_d       = order_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    beat_d        = beat_q;
    proto_err_d   = proto_err_q || (fifo_empty && DATA_FROM_L2_VALID);
    if (push) begin
      stage_valid_d     = 1'b1;
      stage_addr_d      = grant_dat ? ADDR_DAT : ADDR_INS;
      pref_dat_d        = grant_ins;
      order_d[wr_ptr_q] = grant_dat;
      wr_ptr_d          = wr_ptr_q + P'(1);
    end else if (ADDR_TO_L2_READY) begin
      stage_valid_d = 1'b0;
    end else begin
      stage_valid_d = stage_valid_q;
    end
    if (beat_acc) begin
      beat_d = beat_q + BW'(1);
    end else begin
      beat_d = beat_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + P'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (P+1)'(1);
      2'b01:   count_d = count_q - (P+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      pref_dat_q    <= 1'b0;
      order_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      beat_q        <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      pref_dat_q    <= pref_dat_d;
      order_q       <= order_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      beat_q        <= beat_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_l2_read_arbiter.sv
// Self-checking bench for l2_read_arbiter: directed scenarios plus a randomized run against a queue-based reference model.
module tb_l2_read_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic         avi, ari, dvi, dri;
  logic [29:0]  ai;
  logic [127:0] di;
  logic         avd, ard, dvd, drd;
  logic [29:0]  ad;
  logic [127:0] dd;
  logic         l2v, l2r, l2dv, l2dr;
  logic [29:0]  l2a;
  logic [127:0] l2d;
  logic [2:0]   outst;
  logic         perr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l2_read_arbiter dut (
    .CLK(clk), .RSTN(rstn),
    .ADDR_VALID_INS(avi), .ADDR_READY_INS(ari), .ADDR_INS(ai),
    .DATA_VALID_INS(dvi), .DATA_READY_INS(dri), .DATA_INS(di),
    .ADDR_VALID_DAT(avd), .ADDR_READY_DAT(ard), .ADDR_DAT(ad),
    .DATA_VALID_DAT(dvd), .DATA_READY_DAT(drd), .DATA_DAT(dd),
    .ADDR_TO_L2_VALID(l2v), .ADDR_TO_L2_READY(l2r), .ADDR_TO_L2(l2a),
    .DATA_FROM_L2_VALID(l2dv), .DATA_FROM_L2_READY(l2dr), .DATA_FROM_L2(l2d),
    .OUTSTANDING(outst), .PROTO_ERR(perr)
  );

  task automatic idle_inputs();
    avi = 1'b0; ai = 30'h0; dri = 1'b0;
    avd = 1'b0; ad = 30'h0; drd = 1'b0;
    l2r = 1'b0; l2dv = 1'b0; l2d = 128'h0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++;
    if ({l2v, l2a, outst, perr} !== {1'b0, 30'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%0b a=%0h out=%0d perr=%0b required 0/0/0/0", l2v, l2a, outst, perr);
    end
    checks++;
    if ({ari, ard, dvi, dvd, l2dr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b required 00000", {ari, ard, dvi, dvd, l2dr});
    end
  endtask

  task automatic test_single_ins();
    reset_dut();
    avi = 1'b1; ai = 30'h100; l2r = 1'b1;
    #1;
    checks++;
    if ({ari, ard} !== 2'b10) begin
      errors++;
      $display("FAIL single_grant: got %b required 10", {ari, ard});
    end
    @(negedge clk);
    avi = 1'b0;
    #1;
    checks++;
    if ({l2v, l2a, outst, ari} !== {1'b1, 30'h100, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_stage: got v=%0b a=%0h out=%0d rdy=%0b required 1/100/1/0", l2v, l2a, outst, ari);
    end
    dri = 1'b1; drd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      l2dv = 1'b1; l2d = 128'hD0 + 128'(k);
      #1;
      checks++;
      if ({dvi, dvd, l2dr, outst} !== {3'b101, 3'd1} || di !== 128'hD0 + 128'(k)) begin
        errors++;
        $display("FAIL single_beat%0d: got vi=%0b vd=%0b rdy=%0b out=%0d data=%0h required 1/0/1/1/%0h",
                 k, dvi, dvd, l2dr, outst, di, 128'hD0 + 128'(k));
      end
    end
    @(negedge clk);
    l2dv = 1'b0;
    #1;
    checks++;
    if (outst !== 3'd0) begin
      errors++;
      $display("FAIL single_drain: got %0d required 0", outst);
    end
  endtask

  task automatic test_round_robin();
    logic exp_dat;
    reset_dut();
    avi = 1'b1; ai = 30'h10; avd = 1'b1; ad = 30'h20; l2r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (i < 4 && {ari, ard} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b required %b", i, {ari, ard}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end else if (i == 4 && {ari, ard, outst} !== {2'b00, 3'd4}) begin
        errors++;
        $display("FAIL rr_full: got rdy=%b out=%0d required 00/4", {ari, ard}, outst);
      end
      if (i > 0) begin
        checks++;
        if (l2a !== ((i % 2 == 1) ? 30'h10 : 30'h20)) begin
          errors++;
          $display("FAIL rr_addr%0d: got %0h required %0h", i, l2a, (i % 2 == 1) ? 30'h10 : 30'h20);
        end
      end
    end
    dri = 1'b1; drd = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      l2dv = 1'b1; l2d = 128'(j);
      if (j == 5) begin
        avi = 1'b0; avd = 1'b0;
      end
      #1;
      exp_dat = ((j / 4) % 2) == 1;
      checks++;
      if ({dvi, dvd} !== {!exp_dat, exp_dat}) begin
        errors++;
        $display("FAIL rr_route%0d: got vi=%0b vd=%0b required %0b/%0b", j, dvi, dvd, !exp_dat, exp_dat);
      end
      if (j < 5) begin
        checks++;
        if ({ari, ard} !== ((j == 4) ? 2'b10 : 2'b00)) begin
          errors++;
          $display("FAIL rr_refill%0d: got %b required %b", j, {ari, ard}, (j == 4) ? 2'b10 : 2'b00);
        end
      end
    end
  endtask

  task automatic test_l2_stall();
    reset_dut();
    avi = 1'b1; ai = 30'h44;
    #1;
    checks++;
    if (ari !== 1'b1) begin
      errors++;
      $display("FAIL stall_first: got %0b required 1", ari);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      avi = 1'b0; avd = 1'b1; ad = 30'h88;
      #1;
      checks++;
      if ({l2v, l2a, ard} !== {1'b1, 30'h44, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%0b a=%0h rdy=%0b required 1/44/0", c, l2v, l2a, ard);
      end
    end
    @(negedge clk);
    l2r = 1'b1;
    #1;
    checks++;
    if (ard !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got %0b required 1", ard);
    end
    @(negedge clk);
    avd = 1'b0;
    #1;
    checks++;
    if ({l2v, l2a} !== {1'b1, 30'h88}) begin
      errors++;
      $display("FAIL stall_next: got v=%0b a=%0h required 1/88", l2v, l2a);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got_dat[$];
    int k = 0;
    int stall = 0;
    int ins_cnt = 0;
    reset_dut();
    l2r = 1'b1; avi = 1'b1; ai = 30'h200;
    @(negedge clk);
    avi = 1'b0; avd = 1'b1; ad = 30'h300;
    @(negedge clk);
    avd = 1'b0;
    dri = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      l2dv = (k < 8);
      l2d  = 128'hA000 + 128'(k);
      drd  = !(k == 4 && stall < 3);
      #1;
      if (k == 4 && !drd) begin
        checks++;
        if ({l2dr, dvd} !== 2'b01) begin
          errors++;
          $display("FAIL b2b_stall%0d: got rdy=%0b vd=%0b required 0/1", stall, l2dr, dvd);
        end
        stall++;
      end
      if (l2dv && l2dr) begin
        if (dvd && drd) got_dat.push_back(dd);
        if (dvi && dri) ins_cnt++;
        k++;
      end
    end
    checks++;
    if (got_dat.size() != 4 || ins_cnt != 4 || stall != 3) begin
      errors++;
      $display("FAIL b2b_count: got dat=%0d ins=%0d stall=%0d required 4/4/3", got_dat.size(), ins_cnt, stall);
    end
    for (int i = 0; i < got_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== 128'hA004 + 128'(i)) begin
        errors++;
        $display("FAIL b2b_data%0d: got %0h required %0h", i, got_dat[i], 128'hA004 + 128'(i));
      end
    end
    checks++;
    if (outst !== 3'd0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d required 0", outst);
    end
  endtask

  task automatic test_proto_err_reset();
    reset_dut();
    l2dv = 1'b1; l2d = 128'h55; dri = 1'b1; drd = 1'b1;
    #1;
    checks++;
    if ({l2dr, dvi, dvd} !== 3'b000) begin
      errors++;
      $display("FAIL proto_refuse: got %b required 000", {l2dr, dvi, dvd});
    end
    @(negedge clk);
    l2dv = 1'b0;
    #1;
    checks++;
    if (perr !== 1'b1) begin
      errors++;
      $display("FAIL proto_flag: got %0b required 1", perr);
    end
    avi = 1'b1; ai = 30'h7; l2r = 1'b1;
    @(negedge clk);
    avi = 1'b0;
    @(negedge clk);
    l2dv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if ({outst, perr, l2v, dvi, dvd, l2dr} !== {3'd0, 5'b0}) begin
      errors++;
      $display("FAIL midburst_reset: got out=%0d perr=%0b v=%0b vi=%0b vd=%0b rdy=%0b required all 0",
               outst, perr, l2v, dvi, dvd, l2dr);
    end
    l2dv = 1'b0;
  endtask

  task automatic test_random();
    int   q[$];
    bit   m_sv = 1'b0;
    logic [29:0] m_sa = 30'h0;
    bit   last_dat = 1'b1;
    int   beats = 0;
    bit   can, g_i, g_d, e_vi, e_vd, e_rdy;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      avi  = $urandom_range(0, 1) == 1;
      avd  = $urandom_range(0, 1) == 1;
      ai   = 30'($urandom);
      ad   = 30'($urandom);
      l2r  = $urandom_range(0, 3) != 0;
      dri  = $urandom_range(0, 3) != 0;
      drd  = $urandom_range(0, 3) != 0;
      l2dv = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      l2d  = {$urandom, $urandom, $urandom, $urandom};
      can = (!m_sv || l2r) && (q.size() < 4);
      g_i = 1'b0; g_d = 1'b0;
      if (can) begin
        if (avi && avd) begin
          g_i = last_dat; g_d = !last_dat;
        end else begin
          g_i = avi; g_d = avd;
        end
      end
      e_vi = 1'b0; e_vd = 1'b0; e_rdy = 1'b0;
      if (q.size() > 0) begin
        e_vi  = (q[0] == 0) && l2dv;
        e_vd  = (q[0] == 1) && l2dv;
        e_rdy = (q[0] == 1) ? drd : dri;
      end
      #1;
      checks++;
      if ({ari, ard, l2v, dvi, dvd, l2dr} !== {g_i, g_d, m_sv, e_vi, e_vd, e_rdy} || outst !== 3'(q.size())) begin
        errors++;
        $display("FAIL rand_cycle%0d: got %b out=%0d required %b out=%0d", c,
                 {ari, ard, l2v, dvi, dvd, l2dr}, outst, {g_i, g_d, m_sv, e_vi, e_vd, e_rdy}, q.size());
      end
      if (m_sv) begin
        checks++;
        if (l2a !== m_sa) begin
          errors++;
          $display("FAIL rand_addr%0d: got %0h required %0h", c, l2a, m_sa);
        end
      end
      if (l2dv && e_rdy && q.size() > 0) begin
        beats++;
        if (beats == 4) begin
          beats = 0;
          void'(q.pop_front());
        end
      end
      if (g_i || g_d) begin
        m_sv = 1'b1;
        m_sa = g_i ? ai : ad;
        q.push_back(g_d ? 1 : 0);
        last_dat = g_d;
      end else if (l2r) begin
        m_sv = 1'b0;
      end
    end
    checks++;
    if (perr !== 1'b0) begin
      errors++;
      $display("FAIL rand_perr: got %0b required 0", perr);
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_ins();
    test_round_robin();
    test_l2_stall();
    test_back_to_back();
    test_proto_err_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l2_read_arbiter.md
Name: l2_read_arbiter

Overview:
Shares one L2 read port between the instruction cache read-address channel and the data cache read-address channel. Requests are arbitrated round-robin, registered onto a single L2 address channel and logged in an in-order source FIFO. Returned bursts of 2^(B-W) beats are routed back to the requester named at the FIFO head. Sits between the Ins_Cache/Data_Cache L2 read ports and the L2 memory; the data cache write channel bypasses this block.

Parameters:
B, 9, log2 of cache block size in bits (same as the caches).
W, 7, log2 of L2 bus width; L2_BUS_WIDTH = 2^W; BURST = 2^(B-W) beats per request (default 4).
P, 2, log2 of max outstanding requests; ORDER_DEPTH = 2^P (default 4).
AW, 30, word-address width (ADDR_WIDTH-2).

Ports:
CLK  in  1  clock, rising edge.
RSTN  in  1  synchronous active-low reset.
ADDR_VALID_INS  in  1  I-cache read request valid.
ADDR_READY_INS  out  1  I-cache request accepted this cycle.
ADDR_INS  in  AW  I-cache block address.
DATA_VALID_INS  out  1  beat valid to I-cache.
DATA_READY_INS  in  1  I-cache can take beat.
DATA_INS  out  2^W  beat data to I-cache.
ADDR_VALID_DAT  in  1  D-cache read request valid.
ADDR_READY_DAT  out  1  D-cache request accepted.
ADDR_DAT  in  AW  D-cache block address.
DATA_VALID_DAT  out  1  beat valid to D-cache.
DATA_READY_DAT  in  1  D-cache can take beat.
DATA_DAT  out  2^W  beat data to D-cache.
ADDR_TO_L2_VALID  out  1  shared L2 address valid (registered).
ADDR_TO_L2_READY  in  1  L2 accepts address.
ADDR_TO_L2  out  AW  shared L2 address (registered).
DATA_FROM_L2_VALID  in  1  L2 beat valid.
DATA_FROM_L2_READY  out  1  arbiter accepts beat.
DATA_FROM_L2  in  2^W  L2 beat data.
OUTSTANDING  out  P+1  occupancy of order FIFO.
PROTO_ERR  out  1  sticky: L2 beat offered while order FIFO empty.

Behaviour:
- Reset (RSTN=0 at a rising edge): ADDR_TO_L2_VALID=0, ADDR_TO_L2=0, order FIFO empty, OUTSTANDING=0, beat counter=0, PROTO_ERR=0, round-robin pointer = INS preferred. All READY/VALID outputs are 0 while the FIFO is empty and the stage register is empty. Reset mid-burst discards all state; no beats are routed after reset.
- Address stage: one register {valid, addr}. load_en = (!ADDR_TO_L2_VALID | ADDR_TO_L2_READY) & (OUTSTANDING < ORDER_DEPTH). Pop does not bypass full.
- Arbitration (combinational, when load_en): only one requester valid -> grant it. Both valid -> grant the non-preferred side of the last grant (round-robin); after reset INS wins first. ADDR_READY_x = load_en & grant_x; at most one READY high per cycle.
- On grant edge: stage loads the granted address, ADDR_TO_L2_VALID=1 next cycle (latency 1); source id (0=INS, 1=DAT) is pushed to the order FIFO; pointer updates. The stage holds stable while VALID & !READY.
- OUTSTANDING counts pushed-not-completed requests (including the one in the stage). Push and pop in the same cycle leave it unchanged.
- Return path: head = FIFO[rd]. When the FIFO is non-empty, DATA_FROM_L2 is routed combinationally to the head destination: DATA_VALID_head = DATA_FROM_L2_VALID; the other VALID=0; DATA_FROM_L2_READY = DATA_READY_head. DATA_INS/DATA_DAT = DATA_FROM_L2 always (qualified by VALID).
- Beat counter (B-W bits) increments per accepted beat. On the beat with counter = BURST-1 it wraps to 0 and pops the FIFO. The next beat then routes to the new head with no bubble.
- FIFO empty and DATA_FROM_L2_VALID=1: DATA_FROM_L2_READY=0, both DATA_VALID=0, PROTO_ERR set (cleared only by reset).
- Wrap-around: FIFO pointers are P bits and wrap naturally; full is detected by OUTSTANDING = ORDER_DEPTH.

Test Plan:
- Single INS request addr 0x100 with L2 ready -> ADDR_READY_INS=1 for 1 cycle; ADDR_TO_L2=0x100, VALID one cycle later. 4 L2 beats D0..D3 -> DATA_VALID_INS on each, DAT side silent. OUTSTANDING goes 1 then 0 after D3.
- INS 0x10 and DAT 0x20 both valid continuously from reset -> grant order INS, DAT, INS, DAT. The L2 address sequence alternates and the FIFO ids are 0,1,0,1.
- Hold ADDR_TO_L2_READY=0 for 5 cycles with a new DAT request pending -> ADDR_TO_L2 stays stable. ADDR_READY_DAT=0 until the L2 accepts, then granted in the same cycle.
- Issue 4 requests with no data return -> OUTSTANDING=4 and both ADDR_READY stay 0. After the first full 4-beat burst, the fifth request is accepted.
- INS burst then DAT burst back-to-back, with DATA_READY_DAT=0 for 3 cycles on its first beat -> DATA_FROM_L2_READY=0 during the stall, no beat lost. D-cache receives exactly 4 beats in order.
- DATA_FROM_L2_VALID=1 with empty FIFO -> READY=0 and PROTO_ERR=1. RSTN=0 for one cycle mid-burst -> all outputs at reset values, PROTO_ERR=0.
